// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 Viterbi decoder: FSM states,
// code constants and the encoder next-output table used by the ACS unit.
package viterbi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    DRAIN,
    TRACE,
    OUTPUT
  } state_t;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;

  localparam logic [2:0] POLY_G0 = 3'o7;
  localparam logic [2:0] POLY_G1 = 3'o5;

  // Entry {state, input_bit} -> encoder output pair {g0,g1}; entry 0 is leftmost.
  localparam logic [15:0] NEXT_OUT = 16'b00_11_10_01_11_00_01_10;

  function automatic logic [1:0] next_out(input logic [1:0] state, input logic in_bit);
    int idx;
    idx = int'({state, in_bit});
    return NEXT_OUT[15 - 2*idx -: 2];
  endfunction

endpackage

// File: rtl/viterbi_sym_counter.sv
// Loadable up/down counter: symbol index while accepting, traceback bit
// position while tracing. Load has priority over up, up over down.
module viterbi_sym_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (up) begin
      count <= count + W'(1);
    end else if (down) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi datapath: symbol intake, ACS column strobes,
// traceback launch and decoded-word output. Tail mode: VITERBI_CTRL_TAIL_EN.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int COL_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [1:0]           sym_data,
  output logic                 acs_en,
  output logic                 acs_first,
  output logic [1:0]           acs_sym,
  output logic [COL_W-1:0]     acs_col,
  output logic                 tb_start,
  output logic [COL_W-1:0]     tb_col,
  output logic                 tb_from_zero,
  input  logic                 tb_bit_valid,
  input  logic                 tb_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 busy
);

`ifdef VITERBI_CTRL_TAIL_EN
  localparam int   NSYM      = FRAME_LEN + 2;
  localparam logic TAIL_MODE = 1'b1;
`else
  localparam int   NSYM      = FRAME_LEN;
  localparam logic TAIL_MODE = 1'b0;
`endif

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NSYM - 1);

  state_t           state;
  logic [COL_W-1:0] count;
  logic             sym_hs;
  logic             bit_hs;
  logic             cnt_load;
  logic [COL_W-1:0] cnt_load_val;

  assign sym_hs       = sym_valid && sym_ready && (state == IDLE || state == ACCEPT);
  assign bit_hs       = tb_bit_valid && (state == TRACE);
  assign busy         = (state != IDLE);
  assign tb_from_zero = TAIL_MODE;

  // Traceback position starts at NSYM-1 so that, in tail mode, the two
  // positions at or above FRAME_LEN absorb the discarded tail bits.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (state == DRAIN) begin
      cnt_load     = 1'b1;
      cnt_load_val = LAST_COL;
    end else if (state == OUTPUT && out_ready) begin
      cnt_load     = 1'b1;
    end
  end

  viterbi_sym_counter #(
    .W (COL_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .up       (sym_hs),
    .down     (bit_hs),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sym_ready <= 1'b0;
      acs_en    <= 1'b0;
      acs_first <= 1'b0;
      acs_sym   <= '0;
      acs_col   <= '0;
      tb_start  <= 1'b0;
      tb_col    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      acs_en    <= sym_hs;
      acs_first <= sym_hs && (count == '0);
      tb_start  <= 1'b0;
      if (sym_hs) begin
        acs_sym <= sym_data;
        acs_col <= count;
      end

      case (state)
        IDLE, ACCEPT: begin
          sym_ready <= 1'b1;
          if (sym_hs) begin
            if (count == LAST_COL) begin
              sym_ready <= 1'b0;
              state     <= DRAIN;
            end else begin
              state     <= ACCEPT;
            end
          end
        end
        DRAIN: begin
          tb_start <= 1'b1;
          tb_col   <= LAST_COL;
          state    <= TRACE;
        end
        TRACE: begin
          if (bit_hs) begin
            if (count < COL_W'(FRAME_LEN)) begin
              out_data[count[IDX_W-1:0]] <= tb_bit;
            end
            if (count == '0) begin
              out_valid <= 1'b1;
              state     <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sym_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Randomized self-checking bench for viterbi_frame_ctrl against an event-count
// reference model, plus directed frames with literal expected words/latencies.
`timescale 1ns/1ps
module tb_viterbi_frame_ctrl;

  localparam int FRAME_LEN = 16;
  localparam int COL_W     = 5;
`ifdef VITERBI_CTRL_TAIL_EN
  localparam int NSYM = FRAME_LEN + 2;
  localparam bit TAIL = 1'b1;
`else
  localparam int NSYM = FRAME_LEN;
  localparam bit TAIL = 1'b0;
`endif
  localparam int DROP = NSYM - FRAME_LEN;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sym_valid = 1'b0;
  logic                 sym_ready;
  logic [1:0]           sym_data = '0;
  logic                 acs_en, acs_first;
  logic [1:0]           acs_sym;
  logic [COL_W-1:0]     acs_col;
  logic                 tb_start;
  logic [COL_W-1:0]     tb_col;
  logic                 tb_from_zero;
  logic                 tb_bit_valid = 1'b0;
  logic                 tb_bit = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [FRAME_LEN-1:0] out_data;
  logic                 busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int last_bit_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  viterbi_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .COL_W(COL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sym_data     (sym_data),
    .acs_en       (acs_en),
    .acs_first    (acs_first),
    .acs_sym      (acs_sym),
    .acs_col      (acs_col),
    .tb_start     (tb_start),
    .tb_col       (tb_col),
    .tb_from_zero (tb_from_zero),
    .tb_bit_valid (tb_bit_valid),
    .tb_bit       (tb_bit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: counts accepted symbols and received traceback bits.
  int                   m_acc = 0, m_bits = 0, m_cd = 0;
  bit                   m_launched = 0, m_pending = 0, m_ready = 0, m_busy = 0;
  bit                   e_acs_en = 0, e_first = 0, e_tb_start = 0;
  logic [1:0]           e_sym = '0;
  int                   e_col = 0;
  logic [FRAME_LEN-1:0] e_word = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= 0; m_bits <= 0; m_cd <= 0;
      m_launched <= 0; m_pending <= 0; m_ready <= 0; m_busy <= 0;
      e_acs_en <= 0; e_first <= 0; e_tb_start <= 0;
      e_sym <= '0; e_col <= 0; e_word <= '0;
    end else begin : step
      int acc, bits, cd;
      bit launched, pending, hs, start;
      logic [FRAME_LEN-1:0] w;
      acc = m_acc; bits = m_bits; cd = m_cd;
      launched = m_launched; pending = m_pending; w = e_word;
      hs = sym_valid && m_ready;
      start = 0;
      if (launched && tb_bit_valid && bits < NSYM) begin
        if (bits >= DROP) w[FRAME_LEN-1-(bits-DROP)] = tb_bit;
        bits++;
        if (bits == NSYM) begin
          pending = 1;
          launched = 0;
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          launched = 1;
          start = 1;
        end
      end
      if (hs) begin
        e_sym <= sym_data;
        e_col <= acc;
        acc++;
        if (acc == NSYM) cd = 1;
      end
      e_acs_en <= hs;
      e_first  <= hs && (m_acc == 0);
      if (m_pending && out_ready) begin
        pending = 0;
        acc = 0;
        bits = 0;
      end
      e_tb_start <= start;
      m_acc <= acc; m_bits <= bits; m_cd <= cd;
      m_launched <= launched; m_pending <= pending; e_word <= w;
      m_ready <= (acc < NSYM) && !pending && !launched && (cd == 0);
      m_busy  <= !((acc == 0) && !pending && !launched && (cd == 0));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("sym_ready", sym_ready, m_ready);
      check("acs_en", acs_en, e_acs_en);
      check("acs_first", acs_first, e_acs_en && e_first);
      if (e_acs_en) begin
        check("acs_col", acs_col, e_col);
        check("acs_sym", acs_sym, e_sym);
      end
      check("tb_start", tb_start, e_tb_start);
      if (e_tb_start) check("tb_col", tb_col, NSYM - 1);
      check("tb_from_zero", tb_from_zero, TAIL);
      check("out_valid", out_valid, m_pending);
      if (m_pending) check("out_data", out_data, e_word);
      check("busy", busy, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME_LEN+1:0] build_seq(input logic [FRAME_LEN-1:0] w,
                                                     input logic [1:0] junk);
    logic [FRAME_LEN+1:0] s;
    s = '0;
    for (int k = 0; k < NSYM; k++) begin
      if (k < DROP) s[k] = junk[k % 2];
      else          s[k] = w[FRAME_LEN-1-(k-DROP)];
    end
    return s;
  endfunction

  task automatic send_syms(input int n, input int gap_pct, input bit toggle);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 2000) begin
      sym_valid    = toggle ? (guard % 2 == 0) : ($urandom_range(99) >= gap_pct);
      sym_data     = 2'($urandom);
      tb_bit_valid = 1'($urandom);
      tb_bit       = 1'($urandom);
      out_ready    = 1'($urandom);
      if (sym_valid && sym_ready) begin
        got++;
        last_hs_cyc = cyc;
      end
      tick();
      guard++;
    end
    sym_valid    = 1'b0;
    tb_bit_valid = 1'b0;
    if (got < n) timeout("send_syms");
  endtask

  task automatic feed_bits(input logic [FRAME_LEN+1:0] seq, input int gap_pct);
    int guard = 0;
    int k = 0;
    while (!tb_start && guard < 100) begin
      sym_valid = 1'($urandom);
      tick();
      guard++;
    end
    if (!tb_start) begin
      timeout("tb_start_wait");
    end else begin
      check("tb_start_latency", cyc - last_hs_cyc, 2);
    end
    guard = 0;
    while (k < NSYM && guard < 1000) begin
      tb_bit_valid = ($urandom_range(99) >= gap_pct);
      tb_bit       = tb_bit_valid ? seq[k] : 1'($urandom);
      sym_valid    = 1'($urandom);
      out_ready    = 1'($urandom);
      if (tb_bit_valid) begin
        k++;
        last_bit_cyc = cyc;
      end
      tick();
      guard++;
    end
    tb_bit_valid = 1'b0;
    sym_valid    = 1'b0;
    if (k < NSYM) timeout("feed_bits");
  endtask

  task automatic collect_out(input int stall, input logic [FRAME_LEN-1:0] exp_word);
    int guard = 0;
    while (!out_valid && guard < 100) begin
      out_ready = 1'b0;
      tick();
      guard++;
    end
    if (!out_valid) begin
      timeout("out_valid_wait");
    end else begin
      check("out_valid_latency", cyc - last_bit_cyc, 1);
      check("out_word", out_data, exp_word);
      for (int i = 0; i < stall; i++) begin
        out_ready = 1'b0;
        tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_after_out", {busy, out_valid, sym_ready}, 3'b001);
    end
  endtask

  task automatic run_frame(input int sgap, input bit toggle, input int bgap, input int stall,
                           input logic [FRAME_LEN-1:0] w);
    $display("[TB] frame word=%04h sgap=%0d toggle=%0d bgap=%0d stall=%0d", w, sgap, toggle, bgap, stall);
    send_syms(NSYM, sgap, toggle);
    feed_bits(build_seq(w, 2'($urandom)), bgap);
    collect_out(stall, w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_ready", sym_ready, 0);
    check("rst_acs", {acs_en, acs_first, acs_sym, acs_col}, 0);
    check("rst_tb", {tb_start, tb_col}, 0);
    check("rst_out", {out_valid, out_data, busy}, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", sym_ready, 1);

    run_frame(0, 1'b0, 0, 0, 16'h8000);
    run_frame(30, 1'b0, 40, 5, 16'h0001);
    run_frame(0, 1'b1, 0, 0, 16'hA5C3);

    $display("[TB] reset after 7 symbols");
    send_syms(7, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_acs", {acs_en, acs_first, acs_sym, acs_col}, 0);
    check("midrst_tb", {tb_start, tb_col}, 0);
    check("midrst_out", {out_valid, out_data, busy, sym_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    run_frame(0, 1'b0, 0, 0, 16'h1234);

    for (int f = 0; f < 20; f++) begin
      run_frame($urandom_range(60), 1'b0, $urandom_range(60), $urandom_range(4),
                16'($urandom));
    end
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
